// File: rtl/mst_arb_pkg.sv
// Shared types and constants for the FT600 master-FIFO write-path channel scheduler.
package mst_arb_pkg;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    // 245 mode exposes only channel 0.
    localparam logic [NCH-1:0] MASK_245 = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mst_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module mst_rr_pick
    import mst_arb_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic            any,
    output logic [CH_W-1:0] idx
);

    logic [NCH-1:0] rot;

    // rot[k] is the request of channel (ptr + k) mod NCH.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
            logic [CH_W-1:0] ch;
            assign ch      = ptr + CH_W'(gi);
            assign rot[gi] = req[ch];
        end
    endgenerate

    always_comb begin
        any = |rot;
        idx = ptr;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = ptr + CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/mst_chn_arb.sv
// Round-robin write-burst scheduler with per-grant word budget.
// Optional stall timeout is built when MST_ARB_TMO_EN is defined.
module mst_chn_arb
    import mst_arb_pkg::*;
#(
    parameter int BURST_MAX = 1024,
    parameter int CNT_W     = 11,
    parameter int TMO_CYC   = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mltcn,
    input  logic [NCH-1:0]  req,
    input  logic            bus_rdy,
    input  logic            wd_stb,
    input  logic            bst_end,
    output logic            gnt_vld,
    output logic [CH_W-1:0] gnt_id,
    output logic            bst_last,
    output logic            tmo_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_e      state_q, state_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CH_W-1:0] gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NCH-1:0]  req_m;
    logic            pick_any;
    logic [CH_W-1:0] pick_idx;
    logic            tmo_hit;

    assign req_m = mltcn ? req : (req & MASK_245);

    mst_rr_pick u_pick (
        .req (req_m),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // All grant outputs come straight from registers so reset clears them at once.
    assign gnt_vld  = (state_q == ST_GRANT);
    assign gnt_id   = gnt_id_q;
    assign bst_last = gnt_vld && (cnt_q == CNT_LAST);

`ifdef MST_ARB_TMO_EN
    localparam int STALL_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TMO_CYC - 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               tmo_err_q;

    assign tmo_hit = (state_q == ST_GRANT) && (stall_q == STALL_LAST);
    assign tmo_err = tmo_err_q;

    always_comb begin
        stall_d = '0;
        if (state_q == ST_GRANT && !wd_stb) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            tmo_err_q <= tmo_err_q | tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_rdy && pick_any) begin
                    state_d  = ST_GRANT;
                    gnt_id_d = pick_idx;
                    cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                // Saturate: strobes past the budget are a bus FSM protocol error.
                if (wd_stb && (cnt_q != CNT_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (bst_end || (wd_stb && bst_last) || tmo_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                ptr_d   = gnt_id_q + CH_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/mst_chn_arb.md
# mst_chn_arb

Round-robin channel scheduler for the FT600 master FIFO write path (FPGA to host). It sits between the internal per-channel FIFO status and the master FIFO bus state machine. It picks which of the four channels owns the next write burst and enforces a per-burst word budget so that no channel monopolises the bus. In 245 mode only channel 0 is ever granted.

## Interface
Parameters:
- `BURST_MAX`, 1024: maximum words per grant; legal range 2..2048.
- `CNT_W`, 11: word-counter width; must satisfy `2**CNT_W >= BURST_MAX`.
- `TMO_CYC`, 4096: stall timeout in cycles; used only with `MST_ARB_TMO_EN`.

Ports:
- `clk` in 1: single clock; the FIFO bus clock.
- `rst_n` in 1: asynchronous active-low reset.
- `mltcn` in 1: 1 = multi-channel mode, 0 = 245 mode (request mask becomes 4'b0001).
- `req` in 4: per-channel eligibility (internal FIFO not empty AND host channel not full).
- `bus_rdy` in 1: bus FSM is idle and can accept a new burst.
- `wd_stb` in 1: one word of the granted burst was transferred this cycle.
- `bst_end` in 1: bus FSM has terminated the burst (TXE_N rise, empty, or after `bst_last`).
- `gnt_vld` out 1: grant active.
- `gnt_id` out 2: granted channel; valid only while `gnt_vld` = 1.
- `bst_last` out 1: the next `wd_stb` is the final word allowed in this grant.
- `tmo_err` out 1: sticky stall-timeout flag.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE → GRANT when `bus_rdy` = 1 and masked `req` ≠ 0.
  - Winner is the first set bit searching upward, with wrap, from `ptr`.
  - The winner is registered into `gnt_id`.
  - The word counter `cnt` is cleared.
- GRANT:
  - `gnt_vld` = 1.
  - `cnt` increments on each `wd_stb`.
  - `bst_last` = `gnt_vld` AND (`cnt` == `BURST_MAX-1`).
- GRANT → RELEASE on any of:
  - `bst_end`;
  - `wd_stb` while `bst_last` = 1;
  - stall timeout (configuration option).
- RELEASE (one cycle): `gnt_vld` = 0 and `ptr` ← `gnt_id + 1` (mod 4); then go to IDLE.
- Changes to `req` during GRANT are ignored. Ending the burst is the bus FSM's responsibility.
- `wd_stb` and `bst_end` in the same cycle: the word is counted and the state moves to RELEASE.
- `wd_stb` outside GRANT is ignored.
- A change of `mltcn` takes effect at the next arbitration only; a burst in progress is not cut.
- `cnt` never exceeds `BURST_MAX-1`. It saturates if the bus FSM strobes past `bst_last`, which is a protocol violation.
- Reset values: state IDLE, `ptr` = 0, `cnt` = 0, `gnt_vld` = 0, `gnt_id` = 0, `bst_last` = 0, `tmo_err` = 0.
- A reset mid-burst drops the grant immediately (asynchronously).

## Timing
- Arbitration latency: masked `req` and `bus_rdy` sampled high in IDLE → `gnt_vld` high the next cycle.
- Grant release: the terminating event in cycle N → `gnt_vld` low in cycle N+1 (RELEASE) → earliest new grant in cycle N+3.
- Minimum gap between grants is 2 idle cycles.
- `bst_last` is decoded from registers only. It contains no combinational path from `wd_stb` or `bst_end`.
- `gnt_id` is stable for the whole time `gnt_vld` is high.

## Configuration
- `MST_ARB_TMO_EN` defined:
  - A stall counter clears on grant entry and on every `wd_stb`, and increments otherwise during GRANT.
  - On reaching `TMO_CYC-1` the grant is forced to RELEASE and `tmo_err` is set.
  - `tmo_err` stays set until reset.
- `MST_ARB_TMO_EN` undefined: no stall counter is built, `tmo_err` is tied to 0, and a grant lasts until `bst_end` or the budget is exhausted.

## Structure
- Package `mst_arb_pkg` holds:
  - the state encoding (IDLE, GRANT, RELEASE);
  - `NCH` = 4 and `CH_W` = 2;
  - the 245-mode mask constant 4'b0001.
- Sub-module `mst_rr_pick`: combinational rotate-and-priority-encode.
  - Inputs: `req` and `ptr`.
  - Outputs: `any` and `idx`.
  - Instantiated once.

## Test plan
- `mltcn` = 1, `req` = 4'b1111, `bst_end` pulsed after 3 strobes per grant → `gnt_id` sequence 0, 1, 2, 3, 0; `gnt_vld` low for exactly 1 RELEASE cycle plus 1 IDLE cycle between grants.
- `mltcn` = 0, `req` = 4'b1110 → no grant; then `req` = 4'b0001 → `gnt_id` = 0 one cycle after `bus_rdy`.
- `BURST_MAX` = 4, `req[2]` held high, `wd_stb` continuous → `bst_last` high during the 4th strobe; `gnt_vld` low the next cycle; `ptr` = 3; `req` = 4'b0101 then grants ch0.
- `wd_stb` and `bst_end` together on the 2nd word → RELEASE the next cycle; `cnt` at exit = 2.
- `rst_n` asserted low mid-grant → `gnt_vld`, `gnt_id`, and `bst_last` go to 0 without waiting for a clock edge; after release the first grant goes to the lowest set `req` bit (`ptr` = 0).
- With `MST_ARB_TMO_EN` and `TMO_CYC` = 16: grant held with no `wd_stb` → forced release after 16 GRANT cycles, `tmo_err` = 1 and stays at 1 across later grants until `rst_n`.
